// File: rtl/m_ext_sequencer_if.sv
// RV32M sequencer bus: EX request/result side plus multiplier/divider side.
// Latency: none, wiring only.
// Backpressure: m_stall holds EX; units are started by 1-cycle pulses, answered by done pulses.
`timescale 1ns/1ps
interface m_ext_sequencer_if;
   logic        m_req;
   logic [2:0]  m_funct3;
   logic [31:0] m_rs1;
   logic [31:0] m_rs2;
   logic        ex_advance;
   logic        flush;
   logic        m_stall;
   logic [31:0] m_result;
   logic        m_result_valid;
   logic        mul_start;
   logic        mul_done;
   logic [63:0] mul_product;
   logic        div_start;
   logic        div_done;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;
   logic [31:0] unit_op_a;
   logic [31:0] unit_op_b;
   logic [2:0]  unit_funct3;

   // Sequencer side
   modport slave (
      input  m_req, m_funct3, m_rs1, m_rs2, ex_advance, flush,
      input  mul_done, mul_product, div_done, div_quotient, div_remainder,
      output m_stall, m_result, m_result_valid, mul_start, div_start,
      output unit_op_a, unit_op_b, unit_funct3
   );

   // Pipeline / arithmetic unit side
   modport master (
      output m_req, m_funct3, m_rs1, m_rs2, ex_advance, flush,
      output mul_done, mul_product, div_done, div_quotient, div_remainder,
      input  m_stall, m_result, m_result_valid, mul_start, div_start,
      input  unit_op_a, unit_op_b, unit_funct3
   );
endinterface

// File: rtl/m_ext_sequencer.sv
// Sequences one RV32M op at a time through the multi-cycle multiplier/divider, with a 1-entry div/rem cache.
// Latency: cache hit -> result 1 cycle after accept; miss -> 2 + unit latency.
// Backpressure: m_stall = m_req & !m_result_valid; result held until ex_advance or flush.
`timescale 1ns/1ps
module m_ext_sequencer #(
   parameter bit CACHE_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   m_ext_sequencer_if.slave   bus
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE    = 3'd1;
   localparam logic [2:0] S_MUL_WAIT = 3'd2;
   localparam logic [2:0] S_DIV_WAIT = 3'd3;
   localparam logic [2:0] S_HOLD     = 3'd4;
   localparam logic [2:0] S_DRAIN    = 3'd5;

   logic [2:0]  state;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [2:0]  op_f3;
   logic [31:0] result;

   logic        cache_valid;
   logic [31:0] cache_a;
   logic [31:0] cache_b;
   logic        cache_signed;
   logic [31:0] cache_q;
   logic [31:0] cache_r;

   logic        req_is_div;
   logic        req_signed;
   logic        cache_hit;
   logic        cur_is_div;
   logic [31:0] mul_sel;
   logic [31:0] div_sel;
   logic [31:0] cache_sel;

   // Request decode, cache lookup and unit-result selection
   always_comb begin
      req_is_div = bus.m_funct3[2];
      req_signed = ~bus.m_funct3[0];
      cache_hit  = CACHE_EN && cache_valid &&
                   (bus.m_rs1 == cache_a) && (bus.m_rs2 == cache_b) &&
                   (req_signed == cache_signed);
      cache_sel  = bus.m_funct3[1] ? cache_r : cache_q;
      cur_is_div = op_f3[2];
      // MUL takes the low word; MULH/MULHSU/MULHU the high word
      mul_sel    = (op_f3[1:0] == 2'b00) ? bus.mul_product[31:0] : bus.mul_product[63:32];
      // REM/REMU have funct3[1] set
      div_sel    = op_f3[1] ? bus.div_remainder : bus.div_quotient;
   end

   // Main sequencing FSM, operand/result registers and div/rem cache
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         op_a         <= '0;
         op_b         <= '0;
         op_f3        <= '0;
         result       <= '0;
         cache_valid  <= 1'b0;
         cache_a      <= '0;
         cache_b      <= '0;
         cache_signed <= 1'b0;
         cache_q      <= '0;
         cache_r      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.m_req && !bus.flush) begin
                  op_a  <= bus.m_rs1;
                  op_b  <= bus.m_rs2;
                  op_f3 <= bus.m_funct3;
                  if (req_is_div && cache_hit) begin
                     result <= cache_sel;
                     state  <= S_HOLD;
                  end else begin
                     state  <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // A flush here suppresses the start pulse, so nothing is outstanding
               if (bus.flush)
                  state <= S_IDLE;
               else
                  state <= cur_is_div ? S_DIV_WAIT : S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
               if (bus.mul_done) begin
                  if (bus.flush) begin
                     state <= S_IDLE;
                  end else begin
                     result <= mul_sel;
                     state  <= S_HOLD;
                  end
               end else if (bus.flush) begin
                  state <= S_DRAIN;
               end
            end
            S_DIV_WAIT: begin
               if (bus.div_done) begin
                  if (bus.flush) begin
                     state <= S_IDLE;
                  end else begin
                     result <= div_sel;
                     state  <= S_HOLD;
                     if (CACHE_EN) begin
                        cache_valid  <= 1'b1;
                        cache_a      <= op_a;
                        cache_b      <= op_b;
                        cache_signed <= ~op_f3[0];
                        cache_q      <= bus.div_quotient;
                        cache_r      <= bus.div_remainder;
                     end
                  end
               end else if (bus.flush) begin
                  state <= S_DRAIN;
               end
            end
            S_HOLD: begin
               // flush and ex_advance lead to the same place
               if (bus.flush || bus.ex_advance)
                  state <= S_IDLE;
            end
            S_DRAIN: begin
               // Operands are untouched here, so op_f3 still names the busy unit
               if (cur_is_div ? bus.div_done : bus.mul_done)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs: start pulses only in ISSUE and only when not being flushed
   always_comb begin
      bus.m_result_valid = (state == S_HOLD);
      bus.m_stall        = bus.m_req & ~bus.m_result_valid;
      bus.m_result       = result;
      bus.mul_start      = (state == S_ISSUE) & ~cur_is_div & ~bus.flush;
      bus.div_start      = (state == S_ISSUE) &  cur_is_div & ~bus.flush;
      bus.unit_op_a      = op_a;
      bus.unit_op_b      = op_b;
      bus.unit_funct3    = op_f3;
   end

endmodule
